// File: rtl/perceptron_trainer.sv
`default_nettype none
//==============================================================================
// Module   : perceptron_trainer
// Brief    : Perceptron predictor training path: recompute sum, apply threshold
//            rule, queue saturated weight updates and drive the table write port.
// Revision : 1.0 - initial release
//==============================================================================
module perceptron_trainer #(
    parameter int GHR_SIZE   = 12,
    parameter int W          = 8,
    parameter int IDX_BITS   = 6,
    parameter int THETA      = 37,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    execute_trainer_valid,
    output logic                    execute_trainer_ready,
    input  logic [31:0]             execute_trainer_PC,
    input  logic                    execute_trainer_dir,
    input  logic [GHR_SIZE*W-1:0]   execute_trainer_weights,
    input  logic [GHR_SIZE-1:0]     execute_trainer_ghr,
    input  logic                    soin_trainer_stall,
    output logic                    trainer_wren,
    output logic [IDX_BITS-1:0]     trainer_waddr,
    output logic [GHR_SIZE*W-1:0]   trainer_wdata,
    output logic                    trainer_sweeping,
    output logic [31:0]             trainer_train_count
);

    localparam int c_WV    = GHR_SIZE * W;
    localparam int c_SUM_W = W + $clog2(GHR_SIZE);
    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int c_OCC_W = c_CNT_W + 1;

    localparam logic [0:0] c_ST_SWEEP = 1'b0;
    localparam logic [0:0] c_ST_RUN   = 1'b1;

    localparam logic [IDX_BITS-1:0] c_IDX_LAST = '1;
    localparam logic [W-1:0]        c_W_MAX    = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]        c_W_MIN    = {1'b1, {(W-1){1'b0}}};
    localparam logic [c_SUM_W-1:0]  c_THETA    = c_SUM_W'(THETA);
    localparam logic [c_PTR_W-1:0]  c_PTR_LAST = c_PTR_W'(FIFO_DEPTH - 1);
    localparam logic [c_OCC_W-1:0]  c_DEPTH    = c_OCC_W'(FIFO_DEPTH);

    logic [0:0]          r_state;
    logic [0:0]          w_state_next;
    logic [IDX_BITS-1:0] r_sweep_idx;

    logic                r_s1_valid;
    logic                r_s1_dir;
    logic [IDX_BITS-1:0] r_s1_idx;
    logic [c_WV-1:0]     r_s1_weights;
    logic [GHR_SIZE-1:0] r_s1_ghr;

    logic                r_s2_valid;
    logic                r_s2_train;
    logic [IDX_BITS-1:0] r_s2_idx;
    logic [c_WV-1:0]     r_s2_weights;

    logic [IDX_BITS-1:0] r_fifo_idx  [FIFO_DEPTH];
    logic [c_WV-1:0]     r_fifo_data [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic [31:0]         r_train_count;

    logic [c_SUM_W-1:0]  w_sum;
    logic [c_SUM_W-1:0]  w_abs;
    logic                w_train;
    logic [c_WV-1:0]     w_new_weights;
    logic [c_OCC_W-1:0]  w_occ;
    logic                w_accept;
    logic                w_push;
    logic                w_pop;
    logic                w_unused_pc;

    assign w_unused_pc = ^{execute_trainer_PC[31:IDX_BITS+2], execute_trainer_PC[1:0]};
    assign w_accept    = execute_trainer_valid & execute_trainer_ready;
    assign w_occ       = c_OCC_W'(r_count) + c_OCC_W'(r_s1_valid) + c_OCC_W'(r_s2_valid);
    assign trainer_train_count = r_train_count;

    // Perceptron sum over sign-extended terms; sign bit gives the prediction.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < GHR_SIZE; i++) begin
            if (r_s1_ghr[i])
                w_sum = w_sum + {{(c_SUM_W-W){r_s1_weights[W*i+W-1]}}, r_s1_weights[W*i +: W]};
            else
                w_sum = w_sum - {{(c_SUM_W-W){r_s1_weights[W*i+W-1]}}, r_s1_weights[W*i +: W]};
        end
        w_abs   = w_sum[c_SUM_W-1] ? -w_sum : w_sum;
        w_train = (~w_sum[c_SUM_W-1] != r_s1_dir) || (w_abs <= c_THETA);
    end

    always_comb begin
        w_new_weights = r_s1_weights;
        for (int i = 0; i < GHR_SIZE; i++) begin
            if (r_s1_dir == r_s1_ghr[i]) begin
                if (r_s1_weights[W*i +: W] != c_W_MAX)
                    w_new_weights[W*i +: W] = r_s1_weights[W*i +: W] + W'(1);
            end else begin
                if (r_s1_weights[W*i +: W] != c_W_MIN)
                    w_new_weights[W*i +: W] = r_s1_weights[W*i +: W] - W'(1);
            end
        end
    end

    always_comb begin
        w_state_next          = r_state;
        trainer_wren          = 1'b0;
        trainer_waddr         = r_fifo_idx[r_rd_ptr];
        trainer_wdata         = r_fifo_data[r_rd_ptr];
        trainer_sweeping      = 1'b0;
        execute_trainer_ready = 1'b0;
        w_push                = 1'b0;
        w_pop                 = 1'b0;
        case (r_state)
            c_ST_SWEEP: begin
                trainer_wren     = 1'b1;
                trainer_waddr    = r_sweep_idx;
                trainer_wdata    = '0;
                trainer_sweeping = 1'b1;
                if (r_sweep_idx == c_IDX_LAST)
                    w_state_next = c_ST_RUN;
            end
            default: begin
                trainer_wren          = (r_count != '0) && !soin_trainer_stall;
                w_pop                 = trainer_wren;
                w_push                = r_s2_valid && r_s2_train;
                // Credit covers in-flight slots so a push can never overflow.
                execute_trainer_ready = (w_occ < c_DEPTH);
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= c_ST_SWEEP;
            r_sweep_idx   <= '0;
            r_s1_valid    <= 1'b0;
            r_s2_valid    <= 1'b0;
            r_s2_train    <= 1'b0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_train_count <= '0;
        end else begin
            r_state    <= w_state_next;
            r_s1_valid <= w_accept;
            r_s2_valid <= r_s1_valid;
            r_s2_train <= w_train;
            if (r_state == c_ST_SWEEP)
                r_sweep_idx <= r_sweep_idx + IDX_BITS'(1);
            if (w_push) begin
                r_wr_ptr      <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + c_PTR_W'(1);
                r_train_count <= r_train_count + 32'd1;
            end
            if (w_pop)
                r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + c_PTR_W'(1);
            if (w_push && !w_pop)
                r_count <= r_count + c_CNT_W'(1);
            else if (!w_push && w_pop)
                r_count <= r_count - c_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s1_idx     <= execute_trainer_PC[IDX_BITS+1:2];
            r_s1_dir     <= execute_trainer_dir;
            r_s1_weights <= execute_trainer_weights;
            r_s1_ghr     <= execute_trainer_ghr;
        end
        if (r_s1_valid) begin
            r_s2_idx     <= r_s1_idx;
            r_s2_weights <= w_new_weights;
        end
        if (w_push) begin
            r_fifo_idx[r_wr_ptr]  <= r_s2_idx;
            r_fifo_data[r_wr_ptr] <= r_s2_weights;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_perceptron_trainer.sv
`default_nettype none
//==============================================================================
// Module   : tb_perceptron_trainer
// Brief    : Self-checking bench for perceptron_trainer (vector table, corner
//            sequences, randomized branches against an integer reference model).
// Revision : 1.0 - initial release
//==============================================================================
module tb_perceptron_trainer;

    localparam int c_GHR = 12;
    localparam int c_W   = 8;
    localparam int c_WV  = c_GHR * c_W;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              execute_trainer_valid = 1'b0;
    logic              execute_trainer_ready;
    logic [31:0]       execute_trainer_PC = '0;
    logic              execute_trainer_dir = 1'b0;
    logic [c_WV-1:0]   execute_trainer_weights = '0;
    logic [c_GHR-1:0]  execute_trainer_ghr = '0;
    logic              soin_trainer_stall = 1'b0;
    logic              trainer_wren;
    logic [5:0]        trainer_waddr;
    logic [c_WV-1:0]   trainer_wdata;
    logic              trainer_sweeping;
    logic [31:0]       trainer_train_count;

    perceptron_trainer dut (
        .clk                     (clk),
        .reset                   (reset),
        .execute_trainer_valid   (execute_trainer_valid),
        .execute_trainer_ready   (execute_trainer_ready),
        .execute_trainer_PC      (execute_trainer_PC),
        .execute_trainer_dir     (execute_trainer_dir),
        .execute_trainer_weights (execute_trainer_weights),
        .execute_trainer_ghr     (execute_trainer_ghr),
        .soin_trainer_stall      (soin_trainer_stall),
        .trainer_wren            (trainer_wren),
        .trainer_waddr           (trainer_waddr),
        .trainer_wdata           (trainer_wdata),
        .trainer_sweeping        (trainer_sweeping),
        .trainer_train_count     (trainer_train_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]      idx;
        logic [c_WV-1:0] data;
    } wr_t;

    typedef struct {
        logic [31:0]      pc;
        logic             dir;
        logic [c_WV-1:0]  w;
        logic [c_GHR-1:0] ghr;
        logic             train;
        logic [c_WV-1:0]  wdata;
    } vec_t;

    wr_t         exp_q[$];
    logic [31:0] exp_count = '0;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: integer sum, threshold rule and clamped +/-1 update.
    task automatic accept_model(input logic [31:0] pc, input logic d,
                                input logic [c_WV-1:0] w, input logic [c_GHR-1:0] g);
        int sum = 0;
        int wi;
        int n;
        bit train;
        logic [c_WV-1:0] nw;
        for (int i = 0; i < c_GHR; i++) begin
            wi = int'($signed(w[c_W*i +: c_W]));
            sum += g[i] ? wi : -wi;
        end
        train = ((sum >= 0) != d) || (((sum < 0) ? -sum : sum) <= 37);
        for (int i = 0; i < c_GHR; i++) begin
            wi = int'($signed(w[c_W*i +: c_W]));
            n = (d == g[i]) ? wi + 1 : wi - 1;
            if (n > 127) n = 127;
            if (n < -128) n = -128;
            nw[c_W*i +: c_W] = 8'(n);
        end
        if (train) begin
            exp_q.push_back('{pc[7:2], nw});
            exp_count++;
        end
    endtask

    // Every run-state table write must match the head of the expected queue.
    always @(negedge clk) begin : mon
        wr_t e;
        if (trainer_wren && !trainer_sweeping) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write waddr=%0d wdata=%h required=no_write", trainer_waddr, trainer_wdata);
            end else begin
                e = exp_q.pop_front();
                if (trainer_waddr !== e.idx || trainer_wdata !== e.data) begin
                    n_err++;
                    $display("FAIL write_data actual=%0d/%h required=%0d/%h", trainer_waddr, trainer_wdata, e.idx, e.data);
                end
            end
        end
    end

    // Enter just after a rising edge; return just after the accepting edge.
    task automatic send(input logic [31:0] pc, input logic d, input logic [c_WV-1:0] w,
                        input logic [c_GHR-1:0] g, input bit use_model, input bit rand_stall);
        bit done = 0;
        int t = 0;
        execute_trainer_PC      = pc;
        execute_trainer_dir     = d;
        execute_trainer_weights = w;
        execute_trainer_ghr     = g;
        execute_trainer_valid   = 1'b1;
        while (!done && t < 100) begin
            @(negedge clk);
            done = execute_trainer_ready;
            @(posedge clk); #1;
            t++;
            if (rand_stall) soin_trainer_stall = ($urandom_range(0, 2) == 0);
        end
        execute_trainer_valid = 1'b0;
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout ready=0 required=1");
        end else if (use_model) begin
            accept_model(pc, d, w, g);
        end
    endtask

    // Called at a falling edge with the sweep at index 0.
    task automatic check_sweep();
        for (int k = 0; k < 64; k++) begin
            check("sweep_cycle",
                  {trainer_wren, trainer_sweeping, execute_trainer_ready, trainer_waddr, trainer_wdata},
                  {1'b1, 1'b1, 1'b0, 6'(k), {c_WV{1'b0}}});
            @(negedge clk);
        end
        check("post_sweep_ready", {execute_trainer_ready, trainer_sweeping}, 2'b10);
        @(posedge clk); #1;
    endtask

    task automatic drain(input string name);
        int t = 0;
        soin_trainer_stall = 1'b0;
        while (exp_q.size() != 0 && t < 60) begin
            @(posedge clk); #1;
            t++;
        end
        repeat (3) begin @(posedge clk); #1; end
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_count"}, trainer_train_count, exp_count);
    endtask

    function automatic logic [c_WV-1:0] rand_weights();
        logic [c_WV-1:0] w;
        int r;
        for (int i = 0; i < c_GHR; i++) begin
            r = int'($urandom_range(0, 7));
            if (r == 0)      w[c_W*i +: c_W] = 8'h7F;
            else if (r == 1) w[c_W*i +: c_W] = 8'h80;
            else             w[c_W*i +: c_W] = 8'(int'($urandom_range(0, 32)) - 16);
        end
        return w;
    endfunction

    vec_t             tv[9];
    logic [31:0]      bp_pc[6];
    logic [c_GHR-1:0] bp_g[6];
    logic             bp_d[6];

    initial begin
        int acc;
        int wr_seen;
        bit rdy;

        tv[0] = '{32'h0000_0014, 1'b0, {12{8'h00}}, 12'hFFF, 1'b1, {12{8'hFF}}};
        tv[1] = '{32'h0000_0040, 1'b1, {12{8'h10}}, 12'hFFF, 1'b0, {12{8'h00}}};
        tv[2] = '{32'h0000_00FC, 1'b1, {{10{8'h00}}, 8'h81, 8'h7F}, 12'hFFF, 1'b1, {{10{8'h01}}, 8'h82, 8'h7F}};
        tv[3] = '{32'h0000_0008, 1'b0, {{10{8'h00}}, 8'h80, 8'h7F}, 12'h003, 1'b1, {{10{8'h01}}, 8'h80, 8'h7E}};
        tv[4] = '{32'hFFFF_FF04, 1'b1, {12{8'h00}}, 12'h000, 1'b1, {12{8'hFF}}};
        tv[5] = '{32'h0000_0044, 1'b0, {12{8'h10}}, 12'h000, 1'b0, {12{8'h00}}};
        tv[6] = '{32'h0000_0030, 1'b1, {{11{8'h00}}, 8'h25}, 12'h001, 1'b1, {{11{8'hFF}}, 8'h26}};
        tv[7] = '{32'h0000_0034, 1'b1, {{11{8'h00}}, 8'h26}, 12'h001, 1'b0, {12{8'h00}}};
        tv[8] = '{32'h0000_0038, 1'b0, {{11{8'h00}}, 8'h25}, 12'h000, 1'b1, {{11{8'h01}}, 8'h26}};

        // Power-up reset and full sweep.
        #2 reset = 1'b1;
        @(negedge clk);
        check("reset_state",
              {trainer_wren, trainer_sweeping, execute_trainer_ready, trainer_waddr, trainer_wdata, trainer_train_count},
              {1'b1, 1'b1, 1'b0, 6'd0, {c_WV{1'b0}}, 32'd0});
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_sweep();

        // Directed vectors, each with its write-latency profile.
        for (int v = 0; v < 9; v++) begin
            send(tv[v].pc, tv[v].dir, tv[v].w, tv[v].ghr, 1'b0, 1'b0);
            if (tv[v].train) begin
                exp_q.push_back('{tv[v].pc[7:2], tv[v].wdata});
                exp_count++;
            end
            @(negedge clk); check("lat_e0_e1", trainer_wren, 1'b0);
            @(negedge clk); check("lat_e1_e2", trainer_wren, 1'b0);
            @(negedge clk); check("lat_after_e2", trainer_wren, tv[v].train);
            @(posedge clk); #1;
            repeat (2) begin @(posedge clk); #1; end
            check("vec_count", trainer_train_count, exp_count);
            check("vec_written", exp_q.size(), 0);
        end

        // Backpressure: stalled writes, credit limit of four.
        for (int k = 0; k < 6; k++) begin
            bp_pc[k] = 32'h0000_1000 + 32'($urandom_range(0, 63) * 4);
            bp_g[k]  = 12'($urandom);
            bp_d[k]  = 1'($urandom);
        end
        soin_trainer_stall = 1'b1;
        acc = 0;
        wr_seen = 0;
        for (int c = 0; c < 16; c++) begin
            execute_trainer_PC      = bp_pc[acc];
            execute_trainer_dir     = bp_d[acc];
            execute_trainer_weights = '0;
            execute_trainer_ghr     = bp_g[acc];
            execute_trainer_valid   = 1'b1;
            @(negedge clk);
            rdy = execute_trainer_ready;
            if (trainer_wren) wr_seen++;
            @(posedge clk); #1;
            if (rdy) begin
                accept_model(bp_pc[acc], bp_d[acc], '0, bp_g[acc]);
                acc++;
            end
        end
        execute_trainer_valid = 1'b0;
        check("bp_accepted", acc, 4);
        check("bp_no_write_stalled", wr_seen, 0);
        check("bp_ready_low", execute_trainer_ready, 1'b0);
        check("bp_count", trainer_train_count, exp_count);
        soin_trainer_stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("bp_drain_wren", trainer_wren, 1'b1);
        end
        @(negedge clk);
        check("bp_drain_done", {trainer_wren, execute_trainer_ready}, 2'b01);
        @(posedge clk); #1;
        for (int k = 4; k < 6; k++) send(bp_pc[k], bp_d[k], '0, bp_g[k], 1'b1, 1'b0);
        drain("bp");

        // Randomized branches with random stall and gaps.
        for (int k = 0; k < 60; k++) begin
            send($urandom, 1'($urandom), rand_weights(), 12'($urandom), 1'b1, 1'b1);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        drain("rand");

        // Reset with queued, stalled updates.
        soin_trainer_stall = 1'b1;
        for (int k = 0; k < 3; k++)
            send(32'h0000_2000 + 32'(k * 4), 1'b0, '0, 12'hFFF, 1'b1, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        check("mid_queued_count", trainer_train_count, exp_count);
        reset = 1'b1;
        #1;
        check("mid_reset_outputs",
              {execute_trainer_ready, trainer_sweeping, trainer_wren, trainer_waddr, trainer_train_count},
              {1'b0, 1'b1, 1'b1, 6'd0, 32'd0});
        exp_q.delete();
        exp_count = '0;
        @(negedge clk);
        reset = 1'b0;
        check_sweep();
        soin_trainer_stall = 1'b0;
        wr_seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (trainer_wren) wr_seen++;
        end
        check("mid_no_stale_writes", wr_seen, 0);
        check("mid_final_count", trainer_train_count, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
